// File: rtl/entry_controller.sv
// entry_controller: debounces keypad digits into an M:SS entry register and sequences the timer load.
// Optional build macro ENTRY_SEC_CHECK_EN rejects starts whose seconds-tens digit exceeds 5.
module entry_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  bcd,
  input  logic        valid_data,
  input  logic        start,
  input  logic        clear,
  input  logic        timer_zero,
  output logic        enablen,
  output logic [11:0] digits,
  output logic [1:0]  digit_count,
  output logic        load,
  output logic        running,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    RUNNING = 2'd2
  } state_t;

  localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  deb_cnt, deb_cnt_nxt;
  logic [11:0] digits_nxt;
  logic [1:0]  count_nxt;
  logic        start_q;
  logic        start_rise;
  logic        key_done;
  logic        sec_bad;
  logic        load_nxt;
  logic        start_bad;

  assign start_rise = start & ~start_q;
  assign key_done   = valid_data && ((deb_cnt + 4'd1) == DEB_TARGET);

`ifdef ENTRY_SEC_CHECK_EN
  assign sec_bad = digits[7:4] > 4'd5;
`else
  assign sec_bad = 1'b0;
`endif

  // Priority within one edge: clear, then timer_zero, then start, then key capture.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    state_nxt   = state;
    deb_cnt_nxt = deb_cnt;
    digits_nxt  = digits;
    count_nxt   = digit_count;
    load_nxt    = 1'b0;
    start_bad   = 1'b0;

    if (clear) begin
      state_nxt   = IDLE;
      deb_cnt_nxt = 4'd0;
      digits_nxt  = 12'd0;
      count_nxt   = 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_rise && (digit_count != 2'd0)) begin
            // A start that wins over a completing debounce discards that key.
            deb_cnt_nxt = 4'd0;
            if (sec_bad) begin
              start_bad = 1'b1;
            end else begin
              state_nxt = RUNNING;
              load_nxt  = 1'b1;
            end
          end else if (!valid_data) begin
            deb_cnt_nxt = 4'd0;
          end else if (key_done) begin
            digits_nxt  = {digits[7:0], bcd};
            count_nxt   = (digit_count == 2'd3) ? 2'd3 : digit_count + 2'd1;
            deb_cnt_nxt = 4'd0;
            state_nxt   = PRESSED;
          end else begin
            deb_cnt_nxt = deb_cnt + 4'd1;
          end
        end
        PRESSED: begin
          // Held key is ignored until released, giving one digit per press.
          if (!valid_data) begin
            deb_cnt_nxt = 4'd0;
            state_nxt   = IDLE;
          end
        end
        RUNNING: begin
          if (timer_zero) begin
            state_nxt  = IDLE;
            digits_nxt = 12'd0;
            count_nxt  = 2'd0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= IDLE;
      deb_cnt     <= 4'd0;
      digits      <= 12'd0;
      digit_count <= 2'd0;
      start_q     <= 1'b0;
      load        <= 1'b0;
      running     <= 1'b0;
      enablen     <= 1'b0;
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_cnt_nxt;
      digits      <= digits_nxt;
      digit_count <= count_nxt;
      start_q     <= start;
      load        <= load_nxt;
      running     <= (state_nxt == RUNNING);
      enablen     <= (state_nxt == RUNNING);
    end
  end

`ifdef ENTRY_SEC_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= start_bad;
  end
`else
  assign err = 1'b0;
`endif

`ifndef SYNTHESIS
  // The encoder enable and the running flag are the same registered condition.
  a_enablen_running: assert property (@(posedge clk) disable iff (reset) enablen == running);
  a_load_one_cycle:  assert property (@(posedge clk) disable iff (reset) load |=> !load);
  a_load_not_err:    assert property (@(posedge clk) disable iff (reset) !(load && err));
`endif

endmodule

// File: tb/tb_entry_controller.sv
// Self-checking bench for entry_controller: directed test-plan scenarios plus randomized
// key/start/clear traffic compared each cycle against a behavioural model of the entry rules.
module tb_entry_controller;

  localparam int N = 4;
`ifdef ENTRY_SEC_CHECK_EN
  localparam bit SEC_CHECK = 1'b1;
`else
  localparam bit SEC_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  bcd;
  logic        valid_data;
  logic        start;
  logic        clear;
  logic        timer_zero;
  logic        enablen;
  logic [11:0] digits;
  logic [1:0]  digit_count;
  logic        load;
  logic        running;
  logic        err;

  entry_controller #(.DEBOUNCE_CYCLES(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .bcd         (bcd),
    .valid_data  (valid_data),
    .start       (start),
    .clear       (clear),
    .timer_zero  (timer_zero),
    .enablen     (enablen),
    .digits      (digits),
    .digit_count (digit_count),
    .load        (load),
    .running     (running),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural model: the entry value is a number shifted in base 16, the
  // press tracker is a run-length of valid samples plus a "held" flag.
  int m_run_len;
  bit m_held;
  bit m_running;
  int m_value;
  int m_count;
  bit m_start_prev;
  bit m_load;
  bit m_err;

  task automatic model_reset();
    m_run_len = 0; m_held = 0; m_running = 0; m_value = 0;
    m_count = 0; m_start_prev = 0; m_load = 0; m_err = 0;
  endtask

  task automatic model_edge();
    bit start_edge;
    start_edge = start && !m_start_prev;
    m_load = 0;
    m_err  = 0;
    if (clear) begin
      m_running = 0; m_held = 0; m_value = 0; m_count = 0; m_run_len = 0;
    end else if (m_running) begin
      if (timer_zero) begin
        m_running = 0; m_value = 0; m_count = 0;
      end
    end else if (m_held) begin
      if (!valid_data) begin
        m_held = 0; m_run_len = 0;
      end
    end else if (start_edge && m_count > 0) begin
      m_run_len = 0;
      if (SEC_CHECK && ((m_value / 16) % 16) > 5) m_err = 1;
      else begin
        m_load = 1; m_running = 1;
      end
    end else if (valid_data) begin
      m_run_len++;
      if (m_run_len == N) begin
        m_value   = (m_value * 16 + int'(bcd)) % 4096;
        m_count   = (m_count < 3) ? m_count + 1 : 3;
        m_held    = 1;
        m_run_len = 0;
      end
    end else begin
      m_run_len = 0;
    end
    m_start_prev = start;
  endtask

  task automatic compare_all(input string where);
    check({where, ".digits"},      32'(digits),      32'(m_value));
    check({where, ".digit_count"}, 32'(digit_count), 32'(m_count));
    check({where, ".load"},        32'(load),        32'(m_load));
    check({where, ".running"},     32'(running),     32'(m_running));
    check({where, ".enablen"},     32'(enablen),     32'(m_running));
    check({where, ".err"},         32'(err),         32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all("cyc");
  endtask

  task automatic idle_inputs();
    bcd = 4'd0; valid_data = 0; start = 0; clear = 0; timer_zero = 0;
  endtask

  // Clean 6-cycle press; checks the digit lands exactly on the Nth valid edge.
  task automatic press_check(input logic [3:0] d, input logic [11:0] prev, input logic [11:0] exp);
    bcd = d;
    valid_data = 1;
    repeat (N - 1) step();
    check("press.before_land", 32'(digits), 32'(prev));
    step();
    check("press.land", 32'(digits), 32'(exp));
    repeat (6 - N) step();
    valid_data = 0;
    step();
    step();
  endtask

  task automatic start_pulse();
    start = 1;
    step();
    start = 0;
    step();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    @(negedge clk);
    compare_all("reset");
    reset = 0;
    step();

    // Digits 1, 3, 0 -> 1:30.
    press_check(4'd1, 12'h000, 12'h001);
    press_check(4'd3, 12'h001, 12'h013);
    press_check(4'd0, 12'h013, 12'h130);
    check("entry130.count", 32'(digit_count), 32'd3);

    // Start from 1:30, run, then timer_zero.
    start = 1;
    step();
    check("start.load",    32'(load),    32'd1);
    check("start.digits",  32'(digits),  32'h130);
    check("start.running", 32'(running), 32'd1);
    start = 0;
    step();
    check("start.load_fall", 32'(load), 32'd0);
    repeat (5) step();
    check("run.enablen", 32'(enablen), 32'd1);
    timer_zero = 1;
    step();
    timer_zero = 0;
    check("tz.running", 32'(running), 32'd0);
    check("tz.enablen", 32'(enablen), 32'd0);
    check("tz.digits",  32'(digits),  32'd0);

    // Start with nothing entered is ignored.
    start = 1;
    step();
    check("empty_start.load",    32'(load),    32'd0);
    check("empty_start.running", 32'(running), 32'd0);
    start = 0;
    step();

    // 3-cycle glitch is not captured; then 5, 2, 7, 9 keeps the last three.
    bcd = 4'd8;
    valid_data = 1;
    repeat (3) step();
    valid_data = 0;
    step();
    check("glitch.count", 32'(digit_count), 32'd0);
    press_check(4'd5, 12'h000, 12'h005);
    press_check(4'd2, 12'h005, 12'h052);
    press_check(4'd7, 12'h052, 12'h527);
    press_check(4'd9, 12'h527, 12'h279);
    check("entry279.count", 32'(digit_count), 32'd3);

    // Cancel while running.
    start_pulse();
    repeat (3) step();
    clear = 1;
    step();
    clear = 0;
    check("cancel.running", 32'(running), 32'd0);
    check("cancel.enablen", 32'(enablen), 32'd0);
    check("cancel.digits",  32'(digits),  32'd0);
    check("cancel.load",    32'(load),    32'd0);
    step();

    // Asynchronous reset mid-RUNNING, away from any clock edge.
    press_check(4'd4, 12'h000, 12'h004);
    start_pulse();
    step();
    #2;
    reset = 1;
    #1;
    model_reset();
    compare_all("async_reset");
    @(negedge clk);
    reset = 0;
    step();

    // Entry 0:75 exercises the seconds-tens check.
    press_check(4'd0, 12'h000, 12'h000);
    press_check(4'd7, 12'h000, 12'h007);
    press_check(4'd5, 12'h007, 12'h075);
    start = 1;
    step();
    check("sec.err",    32'(err),    32'(SEC_CHECK));
    check("sec.load",   32'(load),   32'(!SEC_CHECK));
    check("sec.digits", 32'(digits), 32'h075);
    start = 0;
    step();
    check("sec.err_fall", 32'(err), 32'd0);
    clear = 1;
    step();
    clear = 0;
    step();

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      int act;
      act = $urandom_range(0, 9);
      if (m_running) begin
        if ($urandom_range(0, 3) == 0) begin
          timer_zero = 1;
          step();
          timer_zero = 0;
        end else if (act == 0) begin
          clear = 1;
          step();
          clear = 0;
        end else begin
          start      = 1'($urandom_range(0, 1));
          valid_data = 1'($urandom_range(0, 1));
          bcd        = 4'($urandom);
          step();
        end
      end else if (act <= 5) begin
        bcd = (act == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        valid_data = 1;
        repeat ($urandom_range(1, 8)) step();
        valid_data = 0;
        repeat ($urandom_range(1, 3)) step();
      end else if (act <= 7) begin
        start = 1;
        repeat ($urandom_range(1, 3)) step();
        start = 0;
        step();
      end else if (act == 8) begin
        clear = 1;
        step();
        clear = 0;
        step();
      end else begin
        repeat (4) begin
          bcd        = 4'($urandom);
          valid_data = 1'($urandom_range(0, 1));
          start      = 1'($urandom_range(0, 1));
          timer_zero = 1'($urandom_range(0, 1));
          clear      = ($urandom_range(0, 7) == 0);
          step();
        end
      end
      idle_inputs();
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/entry_controller.md
# entry_controller

Sequences keypad entry for the cook timer: debounces key presses from the keypad encoder, shifts accepted BCD digits into a 3-digit M:SS entry register, and loads that value into the countdown timer on start. Sits between the keypad encoder and the timer. Gates the encoder through its active-low enable so no keys are accepted while the timer runs.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive sampled-high cycles of `valid_data` required to accept a key (legal 1–15).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `bcd` in 4: digit from the encoder, 0–9.
- `valid_data` in 1: encoder key-valid.
- `start` in 1: start button level; rising edge detected internally.
- `clear` in 1: clear/cancel, level-sensitive.
- `timer_zero` in 1: countdown finished, from the timer.
- `enablen` out 1: active-low encoder enable; 0 in IDLE/PRESSED, 1 in RUNNING.
- `digits` out 12: {min, sec_tens, sec_units}, BCD.
- `digit_count` out 2: digits entered, saturates at 3.
- `load` out 1: one-cycle pulse; the timer captures `digits`.
- `running` out 1: high in RUNNING.
- `err` out 1: one-cycle pulse on a rejected start (see Configuration).

## Operation
- Reset values: state IDLE, `digits`=0, `digit_count`=0, debounce count 0, start-edge register 0, `load`=0, `running`=0, `err`=0, `enablen`=0.
- IDLE: the debounce counter increments each edge `valid_data`=1 and resets to 0 on any edge `valid_data`=0.
  - On the edge the count reaches `DEBOUNCE_CYCLES`: capture `bcd` into sec_units, shift sec_units→sec_tens→min, drop the old min, increment `digit_count` (saturating at 3), then go to PRESSED.
- PRESSED: ignore keys. On the first edge with `valid_data`=0, clear the counter and go to IDLE. This gives one digit per press.
- Start: a rising edge of `start` in IDLE with `digit_count`≠0 goes to RUNNING and pulses `load`.
  - Ignored in IDLE when `digit_count`=0.
  - Ignored in PRESSED and RUNNING.
- RUNNING: `running`=1, `enablen`=1. On `timer_zero`=1, go to IDLE and clear `digits`/`digit_count`.
- `clear` takes effect in any state: go to IDLE, `digits`=0, `digit_count`=0, counter=0. In RUNNING this is a cancel.
- Priority within one edge: `clear` > `timer_zero` > start > key capture. A start edge that coincides with debounce completion loads the existing `digits`, and the key is discarded.
- `bcd` values above 9 while valid are captured unchanged. Range checking is the encoder's job.

## Timing
- Key latency: `valid_data` sampled high on edges k … k+N−1 (N=`DEBOUNCE_CYCLES`). `digits` updates after edge k+N−1.
- Release: the PRESSED→IDLE transition happens on the first edge sampling `valid_data`=0. A new press can then be accepted N edges later.
- Start: `start` sampled 0 then 1 on consecutive edges. `load`=1 and `running`=1 in the cycle after the edge that samples 1. `load` falls after one cycle.
- `enablen`, `running`, `load` and `err` are registered outputs.
- A `reset` assertion clears everything immediately, independent of `clk`, including mid-RUNNING and mid-debounce.

## Configuration
- `ENTRY_SEC_CHECK_EN` defined: a start with sec_tens>5 is rejected.
  - No `load`, state stays IDLE, `digits` are kept.
  - `err` pulses for one cycle with the same timing as `load`.
- Not defined: every start with `digit_count`≠0 is accepted, and `err` is constant 0.

## Test plan
- Reset mid-RUNNING: all outputs go to the reset values immediately, without a clock edge.
- Press 1, 3, 0 with N=4 and clean 6-cycle presses: `digits`=12'h130, `digit_count`=3. Each digit lands 4 edges after its press starts.
- A 3-cycle glitch on `valid_data` with N=4: no capture. Pressing 5, 2, 7, 9: `digits`=12'h279, `digit_count`=3.
- Entry 1:30, then a start pulse: one `load` pulse with `digits`=12'h130 and `running`=1. `enablen`=1 until `timer_zero`, then IDLE with `digits`=0.
- Start with `digit_count`=0: no `load`. `clear` during RUNNING: IDLE, `enablen`=0, `digits`=0, no `load`.
- Entry 0:75 then start: with `ENTRY_SEC_CHECK_EN`, `err` pulses once, no `load`, `digits` stay 12'h075. Without it, `load` pulses and `err`=0.
